dca_matrix_row_loader: RTL and testbench

// Upstream feeder for the DCA matrix register with move-port interface.
// - Accepts a stream of matrix rows on a valid/ready port.
// - Writes exactly MATRIX_SIZE_PARA rows into the register through its move write port.
// - Optionally issues a single transpose pulse after the last row.
// - Signals completion so the consumer can start shift_up/shift_left draining.
//

---
 rtl/dca_matrix_row_loader_if.sv | 28 ++
 rtl/dca_matrix_row_loader.sv | 95 +++++++++
 tb/tb_dca_matrix_row_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dca_matrix_row_loader_if.sv
// rtl/dca_matrix_row_loader_if.sv - row stream and matrix move-port bundle for the row loader
interface dca_matrix_row_loader_if #(
    parameter int BW_ROW = 256
);
    logic              s_valid;
    logic              s_ready;
    logic [BW_ROW-1:0] s_data;
    logic              move_wenable;
    logic [BW_ROW-1:0] move_wdata_list;

    // Upstream feeder / observer side
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  move_wenable,
        input  move_wdata_list
    );

    // Loader side
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output move_wenable,
        output move_wdata_list
    );
endinterface

// File: rtl/dca_matrix_row_loader.sv
// rtl/dca_matrix_row_loader.sv - loads N rows into the DCA matrix register, optional transpose, done pulse
module dca_matrix_row_loader #(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int BW_TENSOR_SCALAR = 32
) (
    input  logic                                        clk,
    input  logic                                        rstnn,
    input  logic                                        start,
    input  logic                                        transpose_req,
    input  logic                                        abort,
    dca_matrix_row_loader_if.slave                      bus,
    output logic                                        transpose,
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(MATRIX_SIZE_PARA+1)-1:0]       row_count
);
    localparam int BW_ROW   = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR;
    localparam int BW_COUNT = $clog2(MATRIX_SIZE_PARA + 1);
    localparam logic [BW_COUNT-1:0] LAST_IDX = BW_COUNT'(MATRIX_SIZE_PARA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        XPOSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BW_COUNT-1:0] row_count_q, row_count_d;
    logic                transpose_q, transpose_d;
    logic                ready;
    logic                accept;

    // Ready is a function of state only, so s_valid never loops back into s_ready
    assign ready                = (state_q == LOAD);
    assign accept               = bus.s_valid & ready;
    assign bus.s_ready          = ready;
    assign bus.move_wenable     = accept;
    assign bus.move_wdata_list  = bus.s_data;
    assign busy                 = (state_q != IDLE);
    assign row_count            = row_count_q;

    // State, row counter and latched transpose request
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= IDLE;
            row_count_q <= '0;
            transpose_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            transpose_q <= transpose_d;
        end
    end

    // Next-state and pulse outputs; abort cancels any active state and suppresses its pulse
    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        transpose_d = transpose_q;
        transpose   = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    row_count_d = '0;
                    transpose_d = transpose_req;
                end
            end
            LOAD: begin
                if (accept) begin
                    row_count_d = row_count_q + 1'b1;
                    if (row_count_q == LAST_IDX) begin
                        state_d = transpose_q ? XPOSE : DONE;
                    end
                end
            end
            XPOSE: begin
                transpose = ~abort;
                state_d   = DONE;
            end
            DONE: begin
                done    = ~abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            row_count_d = '0;
            transpose_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// tb/tb_dca_matrix_row_loader.sv - scoreboard bench for dca_matrix_row_loader
module tb_dca_matrix_row_loader;
    localparam int N      = 4;
    localparam int BW_S   = 8;
    localparam int BW_ROW = N * BW_S;
    localparam int BW_CNT = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rstnn = 1'b0;
    logic              start = 1'b0;
    logic              transpose_req = 1'b0;
    logic              abort = 1'b0;
    logic              transpose;
    logic              busy;
    logic              done;
    logic [BW_CNT-1:0] row_count;

    dca_matrix_row_loader_if #(.BW_ROW(BW_ROW)) bus ();

    dca_matrix_row_loader #(
        .MATRIX_SIZE_PARA (N),
        .BW_TENSOR_SCALAR (BW_S)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .start         (start),
        .transpose_req (transpose_req),
        .abort         (abort),
        .bus           (bus.slave),
        .transpose     (transpose),
        .busy          (busy),
        .done          (done),
        .row_count     (row_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [BW_ROW-1:0] exp_wr[$];
    int                exp_ev[$];   // 1 = transpose pulse, 2 = done pulse

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: seen with nothing expected at %0t", nm, $time);
    endtask

    // Monitor: every strobe and pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rstnn) begin
            if (bus.move_wenable) begin
                if (exp_wr.size() == 0) unexpected("extra_write");
                else chk("write_data", bus.move_wdata_list, exp_wr.pop_front());
            end
            if (transpose) begin
                if (exp_ev.size() == 0) unexpected("transpose_pulse");
                else chk("event_transpose", 32'd1, 32'(exp_ev.pop_front()));
            end
            if (done) begin
                if (exp_ev.size() == 0) unexpected("done_pulse");
                else chk("event_done", 32'd2, 32'(exp_ev.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back known data, 1: random valid + stray start, 2: fixed bubble pattern,
    // 3: valid held high past the last row
    task automatic do_load(input bit xp, input int mode);
        bit v;
        int acc;
        int cyc;
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        transpose_req = xp;
        tick();
        start = 1'b0;
        transpose_req = 1'($urandom_range(0, 1));
        chk("load_ready", 32'(bus.s_ready), 32'd1);
        chk("load_count0", 32'(row_count), 32'd0);
        acc = 0;
        cyc = 0;
        while (acc < N && cyc < 200) begin
            if (mode == 2) v = pat[cyc];
            else if (mode == 1) v = 1'($urandom_range(0, 1));
            else v = 1'b1;
            bus.s_valid = v;
            bus.s_data  = (mode == 0) ? 32'h03020100 + 32'(acc) * 32'h04040404 : $urandom;
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                transpose_req = 1'($urandom_range(0, 1));
            end
            if (v) begin
                exp_wr.push_back(bus.s_data);
                acc++;
            end
            if (acc == N) begin
                if (xp) exp_ev.push_back(1);
                exp_ev.push_back(2);
            end
            tick();
            cyc++;
            chk("row_count", 32'(row_count), 32'(acc));
        end
        if (acc < N) unexpected("load_timeout");
        start = 1'b0;
        if (mode == 3) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
        end else begin
            bus.s_valid = 1'b0;
        end
        if (xp) begin
            chk("xpose_pulse", 32'(transpose), 32'd1);
            chk("xpose_ready", 32'(bus.s_ready), 32'd0);
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_ready", 32'(bus.s_ready), 32'd0);
        chk("done_xpose_low", 32'(transpose), 32'd0);
        tick();
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_done_low", 32'(done), 32'd0);
        chk("after_count", 32'(row_count), 32'(N));
        if (mode == 3) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                chk("held_valid_ready", 32'(bus.s_ready), 32'd0);
            end
            bus.s_valid = 1'b0;
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #12;
        chk("rst_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_wen", 32'(bus.move_wenable), 32'd0);
        chk("rst_xpose", 32'(transpose), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(row_count), 32'd0);
        rstnn = 1'b1;
        tick();

        do_load(1'b0, 0);
        do_load(1'b1, 0);
        do_load(1'b0, 2);
        do_load(1'b0, 3);
        for (int i = 0; i < 6; i++) do_load(1'($urandom_range(0, 1)), 1);

        // abort after two rows, with a row accepted in the abort cycle itself
        start = 1'b1;
        transpose_req = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            exp_wr.push_back(bus.s_data);
            tick();
        end
        abort = 1'b1;
        bus.s_data = $urandom;
        exp_wr.push_back(bus.s_data);
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(row_count), 32'd0);
        chk("abort_ready", 32'(bus.s_ready), 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);
        tick();
        tick();

        // asynchronous reset in the middle of a load
        start = 1'b1;
        transpose_req = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            exp_wr.push_back(bus.s_data);
            tick();
        end
        bus.s_data = $urandom;
        #2;
        rstnn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.s_ready), 32'd0);
        chk("mid_rst_wen", 32'(bus.move_wenable), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(row_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        bus.s_valid = 1'b0;
        #3;
        rstnn = 1'b1;
        tick();
        do_load(1'b1, 1);
        tick();

        chk("writes_left", 32'(exp_wr.size()), 32'd0);
        chk("events_left", 32'(exp_ev.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
